// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds state encoding, widths, the reset vector and the buffer entry layout.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] RESET_ADDR_DEF = 32'h0000_0064;

  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_DROP  = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] align_word(
    input logic [ADDR_W-1:0] a
  );
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO holding fetched {address, instruction} pairs.
// Flush wins over push and pop; the head reads as zero when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign dout = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: one outstanding memory request,
// a small instruction buffer, and redirect with in-flight data drop.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_ADDR = RESET_ADDR_DEF,
  parameter int                DEPTH      = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirectAddr,
  output logic               imemReq,
  output logic [ADDR_W-1:0]  imemAddr,
  input  logic               imemAck,
  input  logic [INSTR_W-1:0] imemData,
  output logic               instrValid,
  output logic [INSTR_W-1:0] instrOut,
  output logic [ADDR_W-1:0]  instrAddr,
  input  logic               instrReady
);

  localparam int            CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] fetch_nxt;
  logic              armed;
  logic              ack;
  logic              push;
  logic              pop;
  logic              hold;
  logic              req_nxt;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_nxt;
  fetch_entry_t      wr_entry;
  fetch_entry_t      head;

  assign ack      = imemReq & imemAck;
  assign push     = ack & (state == ST_FETCH) & ~redirect;
  assign pop      = instrValid & instrReady & ~redirect;
  assign hold     = imemReq & ~ack;
  assign wr_entry = '{addr: imemAddr, instr: imemData};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (wr_entry),
    .dout  (head),
    .count (count)
  );

  assign instrValid = (count != '0);
  assign instrOut   = head.instr;
  assign instrAddr  = head.addr;

  always_comb begin
    count_nxt = count;
    unique case (1'b1)
      redirect:     count_nxt = '0;
      push & ~pop:  count_nxt = count + CW'(1);
      pop & ~push:  count_nxt = count - CW'(1);
      default:      ;
    endcase
  end

  always_comb begin
    fetch_nxt = fetch_addr;
    if (redirect)  fetch_nxt = align_word(redirectAddr);
    else if (push) fetch_nxt = fetch_addr + ADDR_W'(4);
  end

  // A redirect that cannot kill the in-flight request waits for its ack.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_FETCH: if (redirect & hold) state_nxt = ST_DROP;
      ST_DROP:  if (ack) state_nxt = ST_FETCH;
      default:  state_nxt = ST_FETCH;
    endcase
  end

  // armed delays the first request by one edge after reset release.
  assign req_nxt = hold | (armed & (count_nxt < FULL));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_FETCH;
      fetch_addr <= RESET_ADDR;
      armed      <= 1'b0;
      imemReq    <= 1'b0;
      imemAddr   <= RESET_ADDR;
    end else begin
      state      <= state_nxt;
      fetch_addr <= fetch_nxt;
      armed      <= 1'b1;
      imemReq    <= req_nxt;
      if (!hold) imemAddr <= fetch_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a memory responder
// and a queue of expected {addr, instr} pairs.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirectAddr;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic        instrValid;
  logic [31:0] instrOut;
  logic [31:0] instrAddr;
  logic        instrReady;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q [$];

  instr_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .redirect     (redirect),
    .redirectAddr (redirectAddr),
    .imemReq      (imemReq),
    .imemAddr     (imemAddr),
    .imemAck      (imemAck),
    .imemData     (imemData),
    .instrValid   (instrValid),
    .instrOut     (instrOut),
    .instrAddr    (instrAddr),
    .instrReady   (instrReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a * 32'd7) ^ 32'hC0DE_1234;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_req(input string tag, input logic r,
                         input logic [31:0] a);
    chk({tag, "_req"}, 64'(imemReq), 64'(r));
    chk({tag, "_addr"}, 64'(imemAddr), 64'(a));
  endtask

  // One clock cycle: drive inputs, score a pop, record an accepted ack.
  task automatic step(input bit ack, input bit rdy, input bit redir,
                      input logic [31:0] ra, input bit keep,
                      input logic [31:0] ea);
    imemAck      = ack;
    instrReady   = rdy;
    redirect     = redir;
    redirectAddr = ra;
    imemData     = mdata(imemAddr);
    if (redir) begin
      exp_q.delete();
    end else if (instrValid === 1'b1 && rdy) begin
      if (exp_q.size() == 0)
        chk("pop_extra", 64'(exp_q.size()), 64'd1);
      else
        chk("pop", {instrAddr, instrOut}, exp_q.pop_front());
    end
    if (keep) begin
      chk_req("ack", 1'b1, ea);
      exp_q.push_back({ea, mdata(ea)});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, "_req"}, 64'(imemReq), 64'd0);
    chk({tag, "_iaddr"}, 64'(imemAddr), 64'h64);
    chk({tag, "_valid"}, 64'(instrValid), 64'd0);
    chk({tag, "_out"}, 64'(instrOut), 64'd0);
    chk({tag, "_oaddr"}, 64'(instrAddr), 64'd0);
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    imemAck    = 1'b1;
    instrReady = 1'b0;
    redirect   = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk_rst_vals("rst");
    exp_q.delete();
    reset = 1'b1;
    step(1, 0, 0, 0, 0, 0);
    chk("edge1_req", 64'(imemReq), 64'd0);
    step(1, 0, 0, 0, 0, 0);
    chk_req("edge2", 1'b1, 32'h64);
  endtask

  initial begin
    reset        = 1'b0;
    redirect     = 1'b0;
    redirectAddr = '0;
    imemAck      = 1'b0;
    imemData     = '0;
    instrReady   = 1'b0;

    // sequential fetch, ack one cycle after each request
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0, 0);
      chk_req("t1_wait", 1'b1, 32'h64 + 32'(4 * i));
      step(1, 1, 0, 0, 1, 32'h64 + 32'(4 * i));
      chk("t1_lat", 64'(instrValid), 64'd1);
    end
    step(0, 1, 0, 0, 0, 0);

    // buffer fills and stalls until decode pops
    do_reset();
    step(1, 0, 0, 0, 1, 32'h64);
    step(1, 0, 0, 0, 1, 32'h68);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 0);
      chk("t2_noreq", 64'(imemReq), 64'd0);
      chk("t2_hold", {instrAddr, instrOut}, {32'h64, mdata(32'h64)});
    end
    step(1, 1, 0, 0, 0, 0);
    chk_req("t2_after_pop", 1'b1, 32'h6C);
    chk("t2_head", 64'(instrAddr), 64'h68);
    step(0, 1, 0, 0, 0, 0);
    chk("t2_empty", 64'(instrValid), 64'd0);

    // redirect while a request waits; in-flight data is dropped
    do_reset();
    step(1, 1, 0, 0, 1, 32'h64);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 32'h203, 0, 0);
    chk_req("t3_drop", 1'b1, 32'h68);
    chk("t3_flushed", 64'(instrValid), 64'd0);
    step(0, 1, 0, 0, 0, 0);
    chk_req("t3_wait", 1'b1, 32'h68);
    step(1, 1, 0, 0, 0, 0);
    chk("t3_discard", 64'(instrValid), 64'd0);
    chk_req("t3_target", 1'b1, 32'h200);
    step(1, 1, 0, 0, 1, 32'h200);
    chk("t3_head", 64'(instrAddr), 64'h200);
    step(0, 1, 0, 0, 0, 0);

    // redirect with ack and pop in the same cycle
    do_reset();
    step(1, 1, 0, 0, 1, 32'h64);
    step(1, 1, 1, 32'h400, 0, 0);
    chk("t4_empty", 64'(instrValid), 64'd0);
    chk_req("t4_target", 1'b1, 32'h400);
    step(1, 1, 0, 0, 1, 32'h400);
    step(0, 1, 0, 0, 0, 0);

    // redirect again while dropping, then wrap at top of memory
    do_reset();
    step(0, 1, 1, 32'h800, 0, 0);
    step(0, 1, 1, 32'hFFFF_FFFC, 0, 0);
    chk_req("t5_drop", 1'b1, 32'h64);
    step(1, 1, 0, 0, 0, 0);
    chk_req("t5_target", 1'b1, 32'hFFFF_FFFC);
    step(1, 1, 0, 0, 1, 32'hFFFF_FFFC);
    chk_req("t5_wrap", 1'b1, 32'h0);
    step(1, 1, 0, 0, 1, 32'h0);
    step(0, 1, 0, 0, 0, 0);

    // asynchronous reset with one entry buffered and a request pending
    do_reset();
    step(1, 0, 0, 0, 1, 32'h64);
    chk_req("t6_pend", 1'b1, 32'h68);
    reset = 1'b0;
    #1;
    chk_rst_vals("t6_async");
    exp_q.delete();
    do_reset();

    chk("q_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
